step_controller: RTL and testbench
==================================

Name: step_controller

Overview:
- Upstream pacing stage for the program counter. It produces the single-cycle `step_pulse` that advances the PC.
- Debounces raw manual-step and run-toggle push-buttons, and supports manual single-step, free-run at a divided rate, and halt on a breakpoint address.
- It compares the current `pc_address` fed back from the program counter against a breakpoint address.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be >= 2.
- DB_W, 20: width of each debounce counter; must hold DEBOUNCE_CYCLES.
- RUN_DIV, 50000000: clock cycles between automatic steps in RUN (2 Hz at 100 MHz); must be >= 2.
- DIV_W, 26: width of the run divider; must hold RUN_DIV-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_step  input  1  raw, asynchronous manual-step button.
- btn_run  input  1  raw, asynchronous run/stop toggle button.
- bp_enable  input  1  breakpoint enable; synchronous to clk.
- bp_addr  input  5  breakpoint word address; synchronous to clk.
- pc_address  input  5  current PC from the program counter.
- step_pulse  output  1  one-cycle advance strobe to the program counter; registered.
- run_mode  output  1  high while in RUN; registered.
- halted  output  1  high while in HALT; registered.

Behaviour:
- Reset (reset_n low, asynchronous):
  - step_pulse=0, run_mode=0, halted=0.
  - state=IDLE.
  - synchronizer flops, debounced levels, edge-detect flops, debounce counters and run divider all 0.
- Synchronizer: each button passes through its own 2-flop synchronizer before any other logic.
- Debounce, per button, independently:
  - While the synchronized level equals the debounced level, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter returns to 0.
  - Any bounce back to the debounced level resets the counter to 0.
- Events: a debounced 0->1 transition raises a one-cycle internal event (step_ev / run_ev) in the following cycle. Releases generate no event.
- Latency: the raw rising edge is first sampled high at edge N. With the input held stable, step_pulse is high for exactly one cycle starting at edge N+DEBOUNCE_CYCLES+3.
- Simultaneous step_ev and run_ev: run_ev wins in every state; step_ev is dropped.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - step_ev -> step_pulse=1 for one cycle; stay in IDLE.
  - run_ev -> RUN, divider cleared to 0, run_mode=1 from the next cycle.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - At terminal count (RUN_DIV-1), with breakpoint not matched: step_pulse=1 for one cycle.
  - At terminal count, with breakpoint matched (bp_enable=1 and pc_address==bp_addr): no pulse; go to HALT; run_mode=0, halted=1.
  - The breakpoint is evaluated only at terminal count.
  - run_ev -> IDLE, divider cleared, no pulse.
  - step_ev is ignored.
- HALT:
  - step_ev -> step_pulse=1 for one cycle; go to IDLE; halted=0. This steps past the breakpoint.
  - run_ev -> step_pulse=1 for one cycle; go to RUN with divider cleared; run_mode=1, halted=0. The breakpoint at the current PC is not re-checked for this pulse.
- Outputs:
  - step_pulse is never high on two consecutive cycles.
  - run_mode and halted are never high together.
  - Outputs are registered and change one cycle after the causing event or terminal count.
- Mid-operation reset: reset_n low at any point, including mid-debounce or mid-divide, forces the reset values above immediately (asynchronously). No pulse is emitted after release until a new debounced press or RUN terminal count.
- A held button produces only one event; auto-repeat is not supported.

Test Plan:
- DEBOUNCE_CYCLES=4, RUN_DIV=8 for all scenarios.
- Clean step press: btn_step 0->1, held 20 cycles -> exactly one step_pulse, at edge N+7; run_mode=0, halted=0.
- Bouncy press: btn_step toggles 1,0,1,0 on alternate cycles, then stays 1 -> no pulse during the bounce; one pulse 7 cycles after the last 0->1; release bounce produces no pulse.
- Free run: press btn_run, bp_enable=0 -> run_mode=1; step_pulse every 8 cycles, first pulse 8 cycles after RUN entry; btn_step presses in RUN produce no extra pulses; second btn_run press -> IDLE, pulses stop.
- Breakpoint: RUN with bp_enable=1, bp_addr=5, pc_address driven by a PC model advanced by step_pulse from 0 -> pulses while pc 0..4; at pc=5 terminal count, no pulse; halted=1, run_mode=0; btn_step -> one pulse, halted=0, IDLE.
- Resume from HALT: at halt on pc=5, press btn_run -> one immediate step_pulse, run_mode=1; next pulse 8 cycles later; simultaneous btn_step+btn_run debounced on the same cycle -> treated as run_ev only.
- Reset mid-run: assert reset_n=0 at divider count 6 -> all outputs 0 asynchronously; after release, no pulse for 30 cycles with buttons low; state IDLE.

Source files
------------

// File: rtl/step_controller.sv
// Pacing stage for the program counter: debounced step/run buttons, divided free-run
// and breakpoint halt, all funnelled into a single-cycle registered step_pulse.
module step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DB_W            = 20,
    parameter int unsigned RUN_DIV         = 50000000,
    parameter int unsigned DIV_W           = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_step,
    input  logic       btn_run,
    input  logic       bp_enable,
    input  logic [4:0] bp_addr,
    input  logic [4:0] pc_address,
    output logic       step_pulse,
    output logic       run_mode,
    output logic       halted
);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    logic [1:0]       btn_raw_s;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       db_lvl_q;
    logic [1:0]       db_lvl_d;
    logic [1:0]       db_prev_q;
    logic [1:0]       ev_q;
    logic [DB_W-1:0]  db_cnt_q [2];
    logic [DB_W-1:0]  db_cnt_d [2];
    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic             step_pulse_q;
    logic             run_mode_q;
    logic             halted_q;
    logic             step_ev_s;
    logic             run_ev_s;
    logic             bp_hit_s;
    logic             div_tc_s;

    assign btn_raw_s = {btn_run, btn_step};

    // Two-flop synchronizer per button; nothing else ever sees the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] == db_lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_lvl_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_lvl_q  <= 2'b00;
            db_prev_q <= 2'b00;
            ev_q      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            ev_q      <= db_lvl_q & ~db_prev_q;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign step_ev_s = ev_q[BTN_STEP];
    assign run_ev_s  = ev_q[BTN_RUN];
    assign bp_hit_s  = bp_enable && (pc_address == bp_addr);
    assign div_tc_s  = (div_q == DIV_LAST);

    // Mode FSM; run_ev is tested first everywhere so a coincident step_ev is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            step_pulse_q <= 1'b0;
            run_mode_q   <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            step_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    div_q <= '0;
                    if (run_ev_s) begin
                        state_q    <= ST_RUN;
                        run_mode_q <= 1'b1;
                    end else if (step_ev_s) begin
                        step_pulse_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (run_ev_s) begin
                        state_q    <= ST_IDLE;
                        div_q      <= '0;
                        run_mode_q <= 1'b0;
                    end else if (div_tc_s) begin
                        div_q <= '0;
                        if (bp_hit_s) begin
                            state_q    <= ST_HALT;
                            run_mode_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end else begin
                            step_pulse_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_HALT: begin
                    div_q <= '0;
                    if (run_ev_s) begin
                        step_pulse_q <= 1'b1;
                        state_q      <= ST_RUN;
                        run_mode_q   <= 1'b1;
                        halted_q     <= 1'b0;
                    end else if (step_ev_s) begin
                        step_pulse_q <= 1'b1;
                        state_q      <= ST_IDLE;
                        halted_q     <= 1'b0;
                    end else begin
                        state_q <= ST_HALT;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    div_q      <= '0;
                    run_mode_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign step_pulse = step_pulse_q;
    assign run_mode   = run_mode_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: cycle model derived from the behavioural rules plus
// directed scenarios with hand-computed pulse times.
module tb_step_controller;
    localparam int DEB = 4;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_step;
    logic       btn_run;
    logic       bp_enable;
    logic [4:0] bp_addr;
    logic [4:0] pc_m;
    logic       step_pulse;
    logic       run_mode;
    logic       halted;

    int n_cmp    = 0;
    int n_bad    = 0;
    int edge_cnt = 0;
    int dut_q[$];
    int mod_q[$];

    int   raw_h [2][DEB+2];
    logic db_m [2];
    logic rise_m [2];
    logic ev_m [2];
    int   mode_m;
    int   entry_m;
    logic exp_pulse;
    logic exp_run;
    logic exp_halt;

    int e;
    int e0;
    int e1;
    int e2;
    int e3;

    always #5 clk = ~clk;

    step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .DB_W(4),
        .RUN_DIV(DIV),
        .DIV_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_step(btn_step),
        .btn_run(btn_run),
        .bp_enable(bp_enable),
        .bp_addr(bp_addr),
        .pc_address(pc_m),
        .step_pulse(step_pulse),
        .run_mode(run_mode),
        .halted(halted)
    );

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int c = 0;
        foreach (q[i]) if (q[i] > lo && q[i] <= hi) c++;
        return c;
    endfunction

    function automatic int first_after(input int q[$], input int lo);
        foreach (q[i]) if (q[i] > lo) return q[i];
        return -1;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < DEB + 2; k++) raw_h[b][k] = 0;
            db_m[b]   = 1'b0;
            rise_m[b] = 1'b0;
            ev_m[b]   = 1'b0;
        end
        mode_m    = 0;
        entry_m   = 0;
        exp_pulse = 1'b0;
        exp_run   = 1'b0;
        exp_halt  = 1'b0;
        pc_m      = 5'd0;
    endtask

    // mode_m: 0 idle, 1 run, 2 halt. A rising debounced level at edge t acts at t+2.
    task automatic model_step(input int t);
        logic sev;
        logic rev;
        logic acc;
        sev = ev_m[0];
        rev = ev_m[1];
        exp_pulse = 1'b0;
        if (rev) begin
            if (mode_m == 0) begin
                mode_m = 1; entry_m = t;
            end else if (mode_m == 1) begin
                mode_m = 0;
            end else begin
                exp_pulse = 1'b1; mode_m = 1; entry_m = t;
            end
        end else if (mode_m == 1) begin
            if ((t - entry_m) % DIV == 0) begin
                if (bp_enable && pc_m == bp_addr) mode_m = 2;
                else exp_pulse = 1'b1;
            end
        end else if (sev) begin
            exp_pulse = 1'b1;
            mode_m = 0;
        end
        ev_m[0] = rise_m[0];
        ev_m[1] = rise_m[1];
        for (int b = 0; b < 2; b++) begin
            for (int k = DEB + 1; k > 0; k--) raw_h[b][k] = raw_h[b][k-1];
            raw_h[b][0] = (b == 0) ? int'(btn_step) : int'(btn_run);
            acc = 1'b1;
            for (int j = 0; j < DEB; j++) if ((raw_h[b][j+2] != 0) == db_m[b]) acc = 1'b0;
            rise_m[b] = acc && !db_m[b];
            if (acc) db_m[b] = !db_m[b];
        end
        exp_run  = (mode_m == 1);
        exp_halt = (mode_m == 2);
    endtask

    initial begin : model_proc
        model_reset();
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (!reset_n) model_reset();
            else model_step(edge_cnt);
            @(negedge clk);
            if (!reset_n) model_reset();
            check($sformatf("step_pulse@%0d", edge_cnt), int'(step_pulse), int'(exp_pulse));
            check($sformatf("run_mode@%0d", edge_cnt), int'(run_mode), int'(exp_run));
            check($sformatf("halted@%0d", edge_cnt), int'(halted), int'(exp_halt));
            if (step_pulse === 1'b1) dut_q.push_back(edge_cnt);
            if (exp_pulse) begin
                mod_q.push_back(edge_cnt);
                pc_m = pc_m + 5'd1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_to_halt(output int es);
        es = edge_cnt;
        btn_run = 1'b1; tick(12);
        btn_run = 1'b0; tick(58);
        #1;
    endtask

    initial begin : stim
        reset_n = 1'b0; btn_step = 1'b0; btn_run = 1'b0;
        bp_enable = 1'b0; bp_addr = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_step_pulse", int'(step_pulse), 0);
        check("rst_run_mode", int'(run_mode), 0);
        check("rst_halted", int'(halted), 0);
        @(posedge clk); #2 reset_n = 1'b1;
        @(negedge clk);
        tick(5);

        // clean press: first sampled high at e+1, pulse at e+8
        e = edge_cnt;
        btn_step = 1'b1; tick(20);
        btn_step = 1'b0; tick(12); #1;
        check("clean_count", count_in(dut_q, e, edge_cnt), 1);
        check("clean_edge", first_after(dut_q, e), e + 8);
        check("clean_model_edge", first_after(mod_q, e), e + 8);

        // bouncy press: last 0->1 sampled at e+5, pulse at e+12; release bounce silent
        e = edge_cnt;
        btn_step = 1'b1; tick(1); btn_step = 1'b0; tick(1);
        btn_step = 1'b1; tick(1); btn_step = 1'b0; tick(1);
        btn_step = 1'b1; tick(20);
        btn_step = 1'b0; tick(1); btn_step = 1'b1; tick(1);
        btn_step = 1'b0; tick(1); btn_step = 1'b1; tick(1);
        btn_step = 1'b0; tick(20); #1;
        check("bounce_count", count_in(dut_q, e, edge_cnt), 1);
        check("bounce_edge", first_after(dut_q, e), e + 12);

        // free run: entry at e0+8, pulses e0+16..e0+56, stop acts at e0+58
        e0 = edge_cnt;
        btn_run = 1'b1; tick(12);
        btn_run = 1'b0; tick(8);
        btn_step = 1'b1; tick(10);
        btn_step = 1'b0; #1;
        check("run_mode_in_run", int'(run_mode), 1);
        tick(20);
        btn_run = 1'b1; tick(12);
        btn_run = 1'b0; tick(20); #1;
        check("run_count", count_in(dut_q, e0, edge_cnt), 6);
        check("run_first", first_after(dut_q, e0), e0 + 16);
        check("run_model_count", count_in(mod_q, e0, edge_cnt), 6);
        check("run_after_stop", count_in(dut_q, e0 + 58, edge_cnt), 0);
        check("run_mode_stopped", int'(run_mode), 0);

        // breakpoint at pc 5: pulses for pc 0..4, halt at e0+56
        bp_enable = 1'b1; bp_addr = 5'd5;
        do_reset();
        run_to_halt(e0);
        check("bp_count", count_in(dut_q, e0, edge_cnt), 5);
        check("bp_first", first_after(dut_q, e0), e0 + 16);
        check("bp_halted", int'(halted), 1);
        check("bp_run_mode", int'(run_mode), 0);
        check("bp_pc", int'(pc_m), 5);
        e1 = edge_cnt;
        btn_step = 1'b1; tick(10);
        btn_step = 1'b0; tick(20); #1;
        check("halt_step_count", count_in(dut_q, e1, edge_cnt), 1);
        check("halt_step_edge", first_after(dut_q, e1), e1 + 8);
        check("halt_step_halted", int'(halted), 0);
        check("halt_step_run_mode", int'(run_mode), 0);

        // resume from halt: immediate pulse e2+8, next e2+16; stop acts at e2+38
        do_reset();
        run_to_halt(e0);
        check("resume_pre_halted", int'(halted), 1);
        e2 = edge_cnt;
        btn_run = 1'b1; tick(12); #1;
        check("resume_run_mode", int'(run_mode), 1);
        check("resume_halted", int'(halted), 0);
        btn_run = 1'b0; tick(18);
        btn_run = 1'b1; tick(12);
        btn_run = 1'b0; tick(18); #1;
        check("resume_first", first_after(dut_q, e2), e2 + 8);
        check("resume_second", first_after(dut_q, e2 + 8), e2 + 16);
        check("resume_count", count_in(dut_q, e2, edge_cnt), 4);

        // simultaneous presses from idle: run only, entry at e3+8, no pulse
        e3 = edge_cnt;
        btn_step = 1'b1; btn_run = 1'b1; tick(10); #1;
        check("simul_run_mode", int'(run_mode), 1);
        check("simul_no_pulse", count_in(dut_q, e3, edge_cnt), 0);
        btn_step = 1'b0; btn_run = 1'b0; tick(2);

        // reset with the divider at 6 (after edge e3+14)
        @(posedge clk); @(posedge clk); #2;
        check("prerst_run_mode", int'(run_mode), 1);
        reset_n = 1'b0; #1;
        check("async_rst_step_pulse", int'(step_pulse), 0);
        check("async_rst_run_mode", int'(run_mode), 0);
        check("async_rst_halted", int'(halted), 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        tick(30); #1;
        check("post_rst_pulses", count_in(dut_q, e3, edge_cnt), 0);
        check("post_rst_run_mode", int'(run_mode), 0);
        check("post_rst_halted", int'(halted), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
